// File: rtl/ysyx_23060187_mem_pkg.sv
// Shared types and helpers for the memory responder: FSM states, word/mask widths,
// and the byte-lane merge used by the storage write port.
package ysyx_23060187_mem_pkg;

  localparam int WORD_W = 32;
  localparam int MASK_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic [WORD_W-1:0] merge_bytes(
    input logic [WORD_W-1:0] old_word,
    input logic [WORD_W-1:0] wdata,
    input logic [MASK_W-1:0] wmask
  );
    logic [WORD_W-1:0] res;
    for (int i = 0; i < MASK_W; i++) begin
      res[8*i +: 8] = wmask[i] ? wdata[8*i +: 8] : old_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ysyx_23060187_mem_array.sv
// Word-organised storage: one byte-masked synchronous write port and one
// combinational read port. Contents are deliberately not reset.
module ysyx_23060187_mem_array
  import ysyx_23060187_mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  widx_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [MASK_W-1:0] wmask_i,
  input  logic [IDX_W-1:0]  ridx_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[widx_i] <= merge_bytes(mem_q[widx_i], wdata_i, wmask_i);
    end
  end

  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/ysyx_23060187_mem_responder.sv
// Memory-side responder: valid/ready request and response channels in front of
// word storage, fixed access latency, one outstanding transaction.
//   state | meaning
//   IDLE  | ready for a request
//   WAIT  | request latched, latency counter running
//   RESP  | response presented, waiting for rsp_ready_i
module ysyx_23060187_mem_responder
  import ysyx_23060187_mem_pkg::*;
#(
  parameter int          DEPTH   = 1024,
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int          LATENCY = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_wen_i,
  input  logic [31:0]       req_addr_i,
  input  logic [WORD_W-1:0] req_wdata_i,
  input  logic [MASK_W-1:0] req_wmask_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [WORD_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;
  localparam logic DIRECT = (LATENCY == 1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              wen_q;
  logic [31:0]       addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [MASK_W-1:0] wmask_q;
  logic              rsp_valid_q;
  logic [WORD_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;

  logic              req_fire;
  logic              use_req;
  logic              src_wen;
  logic [31:0]       src_addr;
  logic [WORD_W-1:0] src_wdata;
  logic [MASK_W-1:0] src_wmask;
  logic [31:0]       off;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic              commit;
  logic              arr_we;
  logic [WORD_W-1:0] arr_rdata;
  logic [WORD_W-1:0] rdata_d;

  assign req_ready_o = (state_q == IDLE) & ~rst_i;
  assign req_fire    = req_valid_i & req_ready_o;

  // With LATENCY==1 the commit edge is the accept edge, so the live request feeds
  // the commit path; otherwise the latched copy does.
  assign use_req   = (state_q == IDLE);
  assign src_wen   = use_req ? req_wen_i   : wen_q;
  assign src_addr  = use_req ? req_addr_i  : addr_q;
  assign src_wdata = use_req ? req_wdata_i : wdata_q;
  assign src_wmask = use_req ? req_wmask_i : wmask_q;

  assign off      = src_addr - BASE;
  assign in_range = (src_addr >= BASE) && ({1'b0, off} < SPAN);
  assign idx      = off[IDX_W+1:2];

  assign commit = (state_q == IDLE) ? (req_fire & DIRECT)
                                    : ((state_q == WAIT) && (cnt_q == CNT_W'(1)));
  assign arr_we  = commit & src_wen & in_range & (|src_wmask);
  assign rdata_d = (src_wen | ~in_range) ? '0 : arr_rdata;

  ysyx_23060187_mem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (arr_we),
    .widx_i  (idx),
    .wdata_i (src_wdata),
    .wmask_i (src_wmask),
    .ridx_i  (idx),
    .rdata_o (arr_rdata)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wen_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_fire) begin
            wen_q   <= req_wen_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            wmask_q <= req_wmask_i;
            cnt_q   <= CNT_LOAD;
            if (DIRECT) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= rdata_d;
              rsp_err_q   <= ~in_range;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (commit) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rdata_d;
            rsp_err_q   <= ~in_range;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_ysyx_23060187_mem_responder.sv
// Bench for the memory responder: three instances (LATENCY 1, 2, 4) driven by directed
// and random transactions, checked against a word-map reference model.
module tb_ysyx_23060187_mem_responder;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          NI    = 3;

  logic        clk;
  logic        rst       [NI];
  logic        req_valid [NI];
  logic        req_ready [NI];
  logic        req_wen   [NI];
  logic [31:0] req_addr  [NI];
  logic [31:0] req_wdata [NI];
  logic [3:0]  req_wmask [NI];
  logic        rsp_valid [NI];
  logic        rsp_ready [NI];
  logic [31:0] rsp_rdata [NI];
  logic        rsp_err   [NI];

  int total = 0;
  int bad   = 0;

  logic [31:0] mdl [int];

  function automatic int lat(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    ysyx_23060187_mem_responder #(
      .DEPTH   (DEPTH),
      .BASE    (BASE),
      .LATENCY ((g == 0) ? 1 : ((g == 1) ? 2 : 4))
    ) u_dut (
      .clk_i       (clk),
      .rst_i       (rst[g]),
      .req_valid_i (req_valid[g]),
      .req_ready_o (req_ready[g]),
      .req_wen_i   (req_wen[g]),
      .req_addr_i  (req_addr[g]),
      .req_wdata_i (req_wdata[g]),
      .req_wmask_i (req_wmask[g]),
      .rsp_valid_o (rsp_valid[g]),
      .rsp_ready_i (rsp_ready[g]),
      .rsp_rdata_o (rsp_rdata[g]),
      .rsp_err_o   (rsp_err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: memory is a map of words; a write replaces only the enabled byte lanes.
  function automatic void model_txn(input int k, input bit wen, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [3:0] wmask,
                                    output logic [31:0] exp_rd, output bit exp_err);
    longint off;
    int key;
    logic [31:0] w;
    off = longint'(addr) - longint'(BASE);
    exp_err = (off < 0) || ((off / 4) >= DEPTH);
    exp_rd = 32'h0;
    if (!exp_err) begin
      key = k * 4096 + int'(off / 4);
      if (wen) begin
        w = mdl.exists(key) ? mdl[key] : 32'h0;
        for (int i = 0; i < 4; i++) begin
          if (wmask[i]) w[8*i +: 8] = wdata[8*i +: 8];
        end
        mdl[key] = w;
      end else begin
        exp_rd = mdl.exists(key) ? mdl[key] : 32'hxxxx_xxxx;
      end
    end
  endfunction

  task automatic txn(input int k, input bit wen, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] wmask,
                     input int hold, output logic [31:0] rd);
    logic [31:0] exp_rd;
    bit          exp_err;
    int          n;
    model_txn(k, wen, addr, wdata, wmask, exp_rd, exp_err);
    @(negedge clk);
    check_eq("ready_idle", req_ready[k], 1'b1);
    req_valid[k] = 1'b1;
    req_wen[k]   = wen;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    req_wmask[k] = wmask;
    rsp_ready[k] = 1'b0;
    @(posedge clk);
    #1;
    req_valid[k] = 1'b0;
    req_wdata[k] = $urandom;
    n = 0;
    while (!rsp_valid[k] && n < 16) begin
      check_eq("ready_wait", req_ready[k], 1'b0);
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("latency", n, lat(k) - 1);
    check_eq("rdata", rsp_rdata[k], exp_rd);
    check_eq("err", rsp_err[k], exp_err);
    rd = rsp_rdata[k];
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check_eq("hold_valid", rsp_valid[k], 1'b1);
      check_eq("hold_rdata", rsp_rdata[k], rd);
      check_eq("hold_ready", req_ready[k], 1'b0);
    end
    rsp_ready[k] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[k] = 1'b0;
    check_eq("valid_drop", rsp_valid[k], 1'b0);
    check_eq("ready_back", req_ready[k], 1'b1);
  endtask

  // Reset asserted mid-cycle while a response is presented.
  task automatic reset_in_resp(input int k);
    int n;
    @(negedge clk);
    req_valid[k] = 1'b1;
    req_wen[k]   = 1'b0;
    req_addr[k]  = BASE;
    @(posedge clk);
    #1;
    req_valid[k] = 1'b0;
    n = 0;
    while (!rsp_valid[k] && n < 16) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("rst_pre_valid", rsp_valid[k], 1'b1);
    #2;
    rst[k] = 1'b1;
    #1;
    check_eq("rst_valid", rsp_valid[k], 1'b0);
    check_eq("rst_ready", req_ready[k], 1'b0);
    check_eq("rst_rdata", rsp_rdata[k], 32'h0);
    @(negedge clk);
    rst[k] = 1'b0;
    #1;
    check_eq("rst_rel_ready", req_ready[k], 1'b1);
  endtask

  // Write accepted, then reset while still waiting: the write must be dropped.
  task automatic abort_write(input int k, input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    req_valid[k] = 1'b1;
    req_wen[k]   = 1'b1;
    req_addr[k]  = addr;
    req_wdata[k] = data;
    req_wmask[k] = 4'hF;
    @(posedge clk);
    #1;
    req_valid[k] = 1'b0;
    rst[k] = 1'b1;
    #1;
    check_eq("abort_valid", rsp_valid[k], 1'b0);
    check_eq("abort_ready", req_ready[k], 1'b0);
    @(negedge clk);
    rst[k] = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    int r;
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1;
      req_valid[k] = 1'b0;
      req_wen[k] = 1'b0;
      req_addr[k] = '0;
      req_wdata[k] = '0;
      req_wmask[k] = '0;
      rsp_ready[k] = 1'b0;
    end
    #12;
    for (int k = 0; k < NI; k++) begin
      check_eq("reset_ready", req_ready[k], 1'b0);
      check_eq("reset_valid", rsp_valid[k], 1'b0);
    end
    @(negedge clk);
    for (int k = 0; k < NI; k++) rst[k] = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      check_eq("post_rst_ready", req_ready[k], 1'b1);
      check_eq("post_rst_valid", rsp_valid[k], 1'b0);
      check_eq("post_rst_rdata", rsp_rdata[k], 32'h0);
      check_eq("post_rst_err", rsp_err[k], 1'b0);
    end

    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 9; i++) begin
        a = (i < 8) ? BASE + 32'(4 * i) : BASE + 32'(4 * (DEPTH - 1));
        txn(k, 1'b1, a, $urandom, 4'hF, 0, rd);
      end

      txn(k, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, rd);
      txn(k, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, rd);
      check_eq("full_wr_rd", rd, 32'hDEAD_BEEF);
      txn(k, 1'b1, 32'h8000_0010, 32'h0000_5500, 4'b0010, 0, rd);
      txn(k, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, rd);
      check_eq("partial_wr_rd", rd, 32'hDEAD_55EF);
      txn(k, 1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'b0000, 0, rd);
      txn(k, 1'b0, 32'h8000_0013, 32'h0, 4'h0, 5, rd);
      check_eq("nomask_rd", rd, 32'hDEAD_55EF);

      txn(k, 1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 0, rd);
      txn(k, 1'b1, BASE + 32'(4 * DEPTH), 32'hA5A5_A5A5, 4'hF, 0, rd);
      txn(k, 1'b0, BASE, 32'h0, 4'h0, 0, rd);
      txn(k, 1'b0, BASE + 32'(4 * (DEPTH - 1)), 32'h0, 4'h0, 0, rd);

      reset_in_resp(k);
      if (lat(k) > 1) begin
        txn(k, 1'b1, 32'h8000_0020, 32'h0BAD_F00D, 4'hF, 0, rd);
        abort_write(k, 32'h8000_0020, 32'h1234_5678);
        txn(k, 1'b0, 32'h8000_0020, 32'h0, 4'h0, 0, rd);
        check_eq("abort_rd", rd, 32'h0BAD_F00D);
      end

      for (int t = 0; t < 40; t++) begin
        r = $urandom_range(0, 9);
        if (r < 8) a = BASE + 32'(4 * r) + 32'($urandom_range(0, 3));
        else if (r == 8) a = BASE + 32'(4 * (DEPTH - 1));
        else if ($urandom_range(0, 1) == 0) a = 32'($urandom_range(0, 32'h7FFF_FFFF));
        else a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 32'h0FFF_FFFF));
        txn(k, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
            $urandom_range(0, 3), rd);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
